// File: rtl/apu_shared_arbiter.sv
// Round-robin arbiter and result return path for one shared, fixed-latency APU unit.
// A tag pipeline matched to the unit latency routes each result back to its issuing core.
module apu_shared_arbiter #(
  parameter int NB_CORES   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NB_ARGS    = 3,
  parameter int WOP        = 1,
  parameter int NDSFLAGS   = 3,
  parameter int NUSFLAGS   = 8,
  parameter int PIPE_REGS  = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NB_CORES-1:0]                    core_req_i,
  output logic [NB_CORES-1:0]                    core_gnt_o,
  input  logic [NB_CORES*WOP-1:0]                core_op_i,
  input  logic [NB_CORES*NB_ARGS*DATA_WIDTH-1:0] core_operands_i,
  input  logic [NB_CORES*NDSFLAGS-1:0]           core_flags_i,
  output logic                                   unit_valid_o,
  output logic [WOP-1:0]                         unit_op_o,
  output logic [NB_ARGS*DATA_WIDTH-1:0]          unit_operands_o,
  output logic [NDSFLAGS-1:0]                    unit_flags_o,
  input  logic [DATA_WIDTH-1:0]                  unit_result_i,
  input  logic [NUSFLAGS-1:0]                    unit_flags_i,
  output logic [NB_CORES-1:0]                    core_rvalid_o,
  output logic [DATA_WIDTH-1:0]                  core_result_o,
  output logic [NUSFLAGS-1:0]                    core_rflags_o
);

  localparam int ID_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
  localparam int OPW  = NB_ARGS * DATA_WIDTH;

  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     sel_id, idx_id;
  logic                sel_valid;
  int                  idx;
  logic [NB_CORES-1:0] gnt;

  logic                unit_valid_q, unit_valid_d;
  logic [ID_W-1:0]     issue_id_q, issue_id_d;
  logic [WOP-1:0]      unit_op_q, unit_op_d;
  logic [OPW-1:0]      unit_operands_q, unit_operands_d;
  logic [NDSFLAGS-1:0] unit_flags_q, unit_flags_d;

  logic [PIPE_REGS-1:0]           tag_vld_q, tag_vld_d;
  logic [PIPE_REGS-1:0][ID_W-1:0] tag_id_q, tag_id_d;

  logic [NB_CORES-1:0]   rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [NUSFLAGS-1:0]   rflags_q, rflags_d;

  // Scan downwards so the candidate closest to rr_q is the last (winning) assignment.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    idx       = 0;
    idx_id    = '0;
    for (int i = NB_CORES - 1; i >= 0; i--) begin
      idx    = (int'(rr_q) + i) % NB_CORES;
      idx_id = ID_W'(idx);
      if (core_req_i[idx_id]) begin
        sel_valid = 1'b1;
        sel_id    = idx_id;
      end
    end
    if (rst_i) sel_valid = 1'b0;
  end

  always_comb begin
    gnt = '0;
    if (sel_valid) gnt[sel_id] = 1'b1;
  end

  always_comb begin
    rr_d            = rr_q;
    unit_valid_d    = sel_valid;
    issue_id_d      = issue_id_q;
    unit_op_d       = unit_op_q;
    unit_operands_d = unit_operands_q;
    unit_flags_d    = unit_flags_q;
    if (sel_valid) begin
      rr_d            = (sel_id == ID_W'(NB_CORES - 1)) ? '0 : sel_id + 1'b1;
      issue_id_d      = sel_id;
      unit_op_d       = core_op_i[int'(sel_id)*WOP +: WOP];
      unit_operands_d = core_operands_i[int'(sel_id)*OPW +: OPW];
      unit_flags_d    = core_flags_i[int'(sel_id)*NDSFLAGS +: NDSFLAGS];
    end
  end

  // The unit never stalls, so tags advance unconditionally and stay aligned with its pipeline.
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = unit_valid_q;
    tag_id_d[0]  = issue_id_q;
    for (int s = 1; s < PIPE_REGS; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  always_comb begin
    rvalid_d = '0;
    result_d = result_q;
    rflags_d = rflags_q;
    if (tag_vld_q[PIPE_REGS-1]) begin
      rvalid_d[tag_id_q[PIPE_REGS-1]] = 1'b1;
      result_d = unit_result_i;
      rflags_d = unit_flags_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q            <= '0;
      unit_valid_q    <= 1'b0;
      issue_id_q      <= '0;
      unit_op_q       <= '0;
      unit_operands_q <= '0;
      unit_flags_q    <= '0;
      tag_vld_q       <= '0;
      tag_id_q        <= '0;
      rvalid_q        <= '0;
      result_q        <= '0;
      rflags_q        <= '0;
    end else begin
      rr_q            <= rr_d;
      unit_valid_q    <= unit_valid_d;
      issue_id_q      <= issue_id_d;
      unit_op_q       <= unit_op_d;
      unit_operands_q <= unit_operands_d;
      unit_flags_q    <= unit_flags_d;
      tag_vld_q       <= tag_vld_d;
      tag_id_q        <= tag_id_d;
      rvalid_q        <= rvalid_d;
      result_q        <= result_d;
      rflags_q        <= rflags_d;
    end
  end

  assign core_gnt_o      = gnt;
  assign unit_valid_o    = unit_valid_q;
  assign unit_op_o       = unit_op_q;
  assign unit_operands_o = unit_operands_q;
  assign unit_flags_o    = unit_flags_q;
  assign core_rvalid_o   = rvalid_q;
  assign core_result_o   = result_q;
  assign core_rflags_o   = rflags_q;

endmodule

// File: tb/tb_apu_shared_arbiter.sv
// Scoreboard bench for apu_shared_arbiter with a 5-cycle unit model.
// Stimulus pushes expected issue/return records; a monitor pops and compares them.
module tb_apu_shared_arbiter;

  localparam int NBC  = 4;
  localparam int DW   = 32;
  localparam int NA   = 3;
  localparam int WOP  = 1;
  localparam int NDS  = 3;
  localparam int NUS  = 8;
  localparam int PIPE = 5;

  logic                  clk = 1'b0;
  logic                  rst_i = 1'b1;
  logic [NBC-1:0]        core_req_i = '0;
  logic [NBC-1:0]        core_gnt_o;
  logic [NBC*WOP-1:0]    core_op_i = '0;
  logic [NBC*NA*DW-1:0]  core_operands_i = '0;
  logic [NBC*NDS-1:0]    core_flags_i = '0;
  logic                  unit_valid_o;
  logic [WOP-1:0]        unit_op_o;
  logic [NA*DW-1:0]      unit_operands_o;
  logic [NDS-1:0]        unit_flags_o;
  logic [DW-1:0]         unit_result_i;
  logic [NUS-1:0]        unit_flags_i;
  logic [NBC-1:0]        core_rvalid_o;
  logic [DW-1:0]         core_result_o;
  logic [NUS-1:0]        core_rflags_o;

  apu_shared_arbiter #(
    .NB_CORES(NBC), .DATA_WIDTH(DW), .NB_ARGS(NA), .WOP(WOP),
    .NDSFLAGS(NDS), .NUSFLAGS(NUS), .PIPE_REGS(PIPE)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_op_i(core_op_i), .core_operands_i(core_operands_i), .core_flags_i(core_flags_i),
    .unit_valid_o(unit_valid_o), .unit_op_o(unit_op_o),
    .unit_operands_o(unit_operands_o), .unit_flags_o(unit_flags_o),
    .unit_result_i(unit_result_i), .unit_flags_i(unit_flags_i),
    .core_rvalid_o(core_rvalid_o), .core_result_o(core_result_o), .core_rflags_o(core_rflags_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  function automatic logic [DW-1:0] unit_fn(input logic op, input logic [NA*DW-1:0] v);
    logic [DW-1:0] a, b, c;
    a = v[31:0]; b = v[63:32]; c = v[95:64];
    return op ? (a * b + c) : (a + b);
  endfunction

  function automatic logic [NUS-1:0] flag_fn(input logic op, input logic [NA*DW-1:0] v);
    return {op, v[2:0] ^ v[66:64], v[35:32]};
  endfunction

  // Fixed-latency unit model; deliberately not reset so stale results keep appearing.
  logic           m_op [PIPE];
  logic [NA*DW-1:0] m_v [PIPE];
  always @(posedge clk) begin
    m_op[0] <= unit_op_o;
    m_v[0]  <= unit_operands_o;
    for (int i = 1; i < PIPE; i++) begin
      m_op[i] <= m_op[i-1];
      m_v[i]  <= m_v[i-1];
    end
  end
  assign unit_result_i = unit_fn(m_op[PIPE-1], m_v[PIPE-1]);
  assign unit_flags_i  = flag_fn(m_op[PIPE-1], m_v[PIPE-1]);

  typedef struct {int cyc; logic op; logic [NA*DW-1:0] v; logic [NDS-1:0] fl;} iss_t;
  typedef struct {int cyc; logic [NBC-1:0] oh; logic [DW-1:0] res; logic [NUS-1:0] uf;} ret_t;
  iss_t iss_q[$];
  ret_t ret_q[$];

  logic           p_op [NBC];
  logic [DW-1:0]  p_a  [NBC][NA];
  logic [NDS-1:0] p_fl [NBC];
  int seq = 0;
  int last_g = -1;

  task automatic check_output(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic renew(input int k);
    seq++;
    p_op[k]    = seq[0];
    p_a[k][0]  = 32'h0100_0000 * k + seq;
    p_a[k][1]  = seq * 3 + 7;
    p_a[k][2]  = 32'hA5A5_0000 ^ seq;
    p_fl[k]    = NDS'(seq) ^ NDS'(k);
  endtask

  function automatic logic [NA*DW-1:0] pack_v(input int k);
    return {p_a[k][2], p_a[k][1], p_a[k][0]};
  endfunction

  task automatic drive();
    for (int k = 0; k < NBC; k++) begin
      core_op_i[k] = p_op[k];
      core_operands_i[k*NA*DW +: NA*DW] = pack_v(k);
      core_flags_i[k*NDS +: NDS] = p_fl[k];
    end
  endtask

  // One arbitration cycle: drive requests, check the grant, and record expected traffic.
  task automatic apply_stimulus(input logic [NBC-1:0] req, input int exp);
    logic [NBC-1:0] oh;
    iss_t ie;
    ret_t re;
    @(negedge clk);
    if (last_g >= 0) renew(last_g);
    core_req_i = req;
    drive();
    #1;
    oh = (exp >= 0) ? NBC'(1 << exp) : '0;
    check_output("gnt", 128'(core_gnt_o), 128'(oh));
    if (exp >= 0) begin
      ie.cyc = cyc + 1; ie.op = p_op[exp]; ie.v = pack_v(exp); ie.fl = p_fl[exp];
      iss_q.push_back(ie);
      re.cyc = cyc + 2 + PIPE; re.oh = oh;
      re.res = unit_fn(p_op[exp], pack_v(exp));
      re.uf  = flag_fn(p_op[exp], pack_v(exp));
      ret_q.push_back(re);
    end
    last_g = exp;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_gnt"},      128'(core_gnt_o), 128'(0));
    check_output({tag, "_uvalid"},   128'(unit_valid_o), 128'(0));
    check_output({tag, "_uop"},      128'(unit_op_o), 128'(0));
    check_output({tag, "_uoperands"},128'(unit_operands_o), 128'(0));
    check_output({tag, "_uflags"},   128'(unit_flags_o), 128'(0));
    check_output({tag, "_rvalid"},   128'(core_rvalid_o), 128'(0));
    check_output({tag, "_result"},   128'(core_result_o), 128'(0));
    check_output({tag, "_rflags"},   128'(core_rflags_o), 128'(0));
  endtask

  // Monitor: compares whatever the DUT presents against the head of each queue.
  initial begin
    iss_t ie;
    ret_t re;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_i) begin
        while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
          ie = iss_q.pop_front();
          check_output("issue_missing", 128'(cyc), 128'(ie.cyc));
        end
        if (unit_valid_o) begin
          if (iss_q.size() == 0) check_output("issue_unexpected", 128'(unit_valid_o), 128'(0));
          else begin
            ie = iss_q.pop_front();
            check_output("issue_cycle", 128'(cyc), 128'(ie.cyc));
            check_output("issue_op", 128'(unit_op_o), 128'(ie.op));
            check_output("issue_operands", 128'(unit_operands_o), 128'(ie.v));
            check_output("issue_flags", 128'(unit_flags_o), 128'(ie.fl));
          end
        end
        while (ret_q.size() > 0 && ret_q[0].cyc < cyc) begin
          re = ret_q.pop_front();
          check_output("ret_missing", 128'(cyc), 128'(re.cyc));
        end
        if (core_rvalid_o != '0) begin
          if (ret_q.size() == 0) check_output("ret_unexpected", 128'(core_rvalid_o), 128'(0));
          else begin
            re = ret_q.pop_front();
            check_output("ret_cycle", 128'(cyc), 128'(re.cyc));
            check_output("ret_onehot", 128'(core_rvalid_o), 128'(re.oh));
            check_output("ret_result", 128'(core_result_o), 128'(re.res));
            check_output("ret_flags", 128'(core_rflags_o), 128'(re.uf));
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < NBC; k++) renew(k);
    drive();
    core_req_i = '1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    core_req_i = '0;
    rst_i = 1'b0;

    // Full contention from reset: strict rotation 0,1,2,3,...
    for (int i = 0; i < 8; i++) apply_stimulus(4'b1111, i % 4);
    repeat (2) apply_stimulus(4'b0000, -1);

    // Lone request from core 2.
    apply_stimulus(4'b0100, 2);
    repeat (PIPE + 3) apply_stimulus(4'b0000, -1);

    // Pointer wrap: after core 3, core 0 wins before core 3 again.
    apply_stimulus(4'b1000, 3);
    apply_stimulus(4'b1001, 0);
    apply_stimulus(4'b1000, 3);

    // Core 1 holds while core 0 keeps re-requesting.
    apply_stimulus(4'b0011, 0);
    apply_stimulus(4'b0011, 1);
    repeat (PIPE + 3) apply_stimulus(4'b0000, -1);

    // Three operations in flight, then reset discards them.
    apply_stimulus(4'b1111, 2);
    apply_stimulus(4'b1111, 3);
    apply_stimulus(4'b1111, 0);
    @(negedge clk);
    rst_i = 1'b1;
    core_req_i = 4'b1111;
    last_g = -1;
    #1;
    check_reset_outputs("midreset");
    iss_q.delete();
    ret_q.delete();
    repeat (2) @(negedge clk);
    core_req_i = '0;
    rst_i = 1'b0;
    repeat (PIPE + 4) apply_stimulus(4'b0000, -1);

    // Pointer restarts at 0 after reset.
    apply_stimulus(4'b1001, 0);
    apply_stimulus(4'b0110, 1);
    apply_stimulus(4'b0110, 2);
    repeat (PIPE + 4) apply_stimulus(4'b0000, -1);

    check_output("issue_queue_drained", 128'(iss_q.size()), 128'(0));
    check_output("ret_queue_drained", 128'(ret_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
